// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// regfile_dump_ctrl : runs the CPU for a programmed number of cycles, then
//                     freezes it and streams every register out over valid/ready.
// Rev 1.0
// ============================================================================
module regfile_dump_ctrl #(
   parameter int NUM_REGS = 32,
   parameter int IDX_W    = 5,
   parameter int DATA_W   = 32,
   parameter int CYC_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [CYC_W-1:0]  num_cycles_i,
   input  logic [IDX_W-1:0]  cpu_readRegA_i,
   output logic [IDX_W-1:0]  rf_readRegA_o,
   input  logic [DATA_W-1:0] rf_dataA_i,
   output logic              cpu_run_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [CYC_W-1:0]  cycle_count_o,
   output logic              dump_valid_o,
   input  logic              dump_ready_i,
   output logic [IDX_W-1:0]  dump_idx_o,
   output logic [DATA_W-1:0] dump_data_o
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_SCAN_RD  = 3'd2,
      S_SCAN_OUT = 3'd3,
      S_DONE     = 3'd4
   } state_e;

   state_e              state_q;
   logic [CYC_W-1:0]    num_q;
   logic [CYC_W-1:0]    cycle_count_q;
   logic [CYC_W-1:0]    cycle_count_d;
   logic [IDX_W-1:0]    idx_q;
   logic [DATA_W-1:0]   dump_data_q;
   logic                cpu_run_q;
   logic                busy_q;
   logic                done_q;
   logic                dump_valid_q;
   logic                scan_sel;

   assign cycle_count_d = cycle_count_q + 1'b1;
   assign scan_sel      = (state_q == S_SCAN_RD) || (state_q == S_SCAN_OUT);

   // The controller owns regfile port A only while scanning.
   assign rf_readRegA_o = scan_sel ? idx_q : cpu_readRegA_i;

   assign cpu_run_o     = cpu_run_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign cycle_count_o = cycle_count_q;
   assign dump_valid_o  = dump_valid_q;
   assign dump_idx_o    = idx_q;
   assign dump_data_o   = dump_data_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= S_IDLE;
         num_q         <= '0;
         cycle_count_q <= '0;
         idx_q         <= '0;
         dump_data_q   <= '0;
         cpu_run_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         dump_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  num_q         <= num_cycles_i;
                  cycle_count_q <= '0;
                  idx_q         <= '0;
                  done_q        <= 1'b0;
                  busy_q        <= 1'b1;
                  if (num_cycles_i == '0) begin
                     state_q <= S_SCAN_RD;
                  end else begin
                     cpu_run_q <= 1'b1;
                     state_q   <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               cycle_count_q <= cycle_count_d;
               if (cycle_count_d == num_q) begin
                  cpu_run_q <= 1'b0;
                  idx_q     <= '0;
                  state_q   <= S_SCAN_RD;
               end
            end
            S_SCAN_RD: begin
               dump_data_q  <= rf_dataA_i;
               dump_valid_q <= 1'b1;
               state_q      <= S_SCAN_OUT;
            end
            S_SCAN_OUT: begin
               if (dump_ready_i) begin
                  dump_valid_q <= 1'b0;
                  if (idx_q == LAST_IDX) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_SCAN_RD;
                  end
               end
            end
            default: begin
               cpu_run_q    <= 1'b0;
               busy_q       <= 1'b0;
               done_q       <= 1'b0;
               dump_valid_q <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// tb_regfile_dump_ctrl : randomized run/dump scenarios against a regfile model.
// Rev 1.0
// ============================================================================
module tb_regfile_dump_ctrl;

   localparam int NUM_REGS = 32;
   localparam int IDX_W    = 5;
   localparam int DATA_W   = 32;
   localparam int CYC_W    = 16;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic [CYC_W-1:0]  num_cycles;
   logic [IDX_W-1:0]  cpu_readRegA;
   logic [IDX_W-1:0]  rf_readRegA;
   logic [DATA_W-1:0] rf_dataA;
   logic              cpu_run;
   logic              busy;
   logic              done;
   logic [CYC_W-1:0]  cycle_count;
   logic              dump_valid;
   logic              dump_ready;
   logic [IDX_W-1:0]  dump_idx;
   logic [DATA_W-1:0] dump_data;

   logic [DATA_W-1:0] rf [NUM_REGS];
   assign rf_dataA = rf[rf_readRegA];

   regfile_dump_ctrl #(
      .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DATA_W(DATA_W), .CYC_W(CYC_W)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .num_cycles_i  (num_cycles),
      .cpu_readRegA_i(cpu_readRegA),
      .rf_readRegA_o (rf_readRegA),
      .rf_dataA_i    (rf_dataA),
      .cpu_run_o     (cpu_run),
      .busy_o        (busy),
      .done_o        (done),
      .cycle_count_o (cycle_count),
      .dump_valid_o  (dump_valid),
      .dump_ready_i  (dump_ready),
      .dump_idx_o    (dump_idx),
      .dump_data_o   (dump_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Observations gathered by run_dump; each test judges them against the model.
   int                obs_idx  [$];
   logic [DATA_W-1:0] obs_data [$];
   int                obs_cc   [$];
   int obs_run, obs_first_valid, obs_hold_bad, obs_sel_bad;
   int obs_min_gap, obs_max_gap, obs_stall, obs_final_cc;
   bit obs_timeout, obs_done;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready always 1; 1: random ready; 2: hold ready low 4 clocks on idx 7
   task automatic run_dump(input int ncyc, input int mode, input int abort_idx, input bit inject);
      int last_hs;
      bit pv, phs;
      logic [IDX_W-1:0]  pidx;
      logic [DATA_W-1:0] pdata;
      obs_idx.delete(); obs_data.delete(); obs_cc.delete();
      obs_run = 0; obs_first_valid = -1; obs_hold_bad = 0; obs_sel_bad = 0;
      obs_min_gap = 1000000; obs_max_gap = 0; obs_stall = 0; obs_final_cc = -1;
      obs_timeout = 1'b1; obs_done = 1'b0;
      last_hs = -1; pv = 1'b0; phs = 1'b0; pidx = '0; pdata = '0;
      num_cycles = CYC_W'(ncyc);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int s = 0; s < 4000; s++) begin
         if (cpu_run) begin
            obs_run++;
            obs_cc.push_back(int'(cycle_count));
         end
         if (dump_valid && obs_first_valid < 0) obs_first_valid = s;
         if (pv && !phs && (!dump_valid || dump_idx !== pidx || dump_data !== pdata)) obs_hold_bad++;
         if (dump_valid) begin
            if (rf_readRegA !== dump_idx) obs_sel_bad++;
         end else if ((!busy || cpu_run) && rf_readRegA !== cpu_readRegA) begin
            obs_sel_bad++;
         end
         if (done) begin
            obs_done = 1'b1;
            obs_timeout = 1'b0;
            obs_final_cc = int'(cycle_count);
            break;
         end
         if (abort_idx >= 0 && dump_valid && int'(dump_idx) == abort_idx) begin
            rst_n = 1'b0;
            obs_timeout = 1'b0;
            break;
         end
         case (mode)
            1: dump_ready = 1'($urandom_range(0, 1));
            2: begin
               if (dump_valid && dump_idx == 5'd7 && obs_stall < 4) begin
                  dump_ready = 1'b0;
                  obs_stall++;
               end else begin
                  dump_ready = 1'b1;
               end
            end
            default: dump_ready = 1'b1;
         endcase
         if (dump_valid && dump_ready) begin
            obs_idx.push_back(int'(dump_idx));
            obs_data.push_back(dump_data);
            if (last_hs >= 0) begin
               if (s - last_hs < obs_min_gap) obs_min_gap = s - last_hs;
               if (s - last_hs > obs_max_gap) obs_max_gap = s - last_hs;
            end
            last_hs = s;
         end
         pv = dump_valid; pidx = dump_idx; pdata = dump_data; phs = dump_valid && dump_ready;
         cpu_readRegA = IDX_W'($urandom);
         if (inject && busy) begin
            start      = 1'($urandom_range(0, 1));
            num_cycles = CYC_W'($urandom_range(1, 50));
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic fill_rf_random();
      for (int i = 0; i < NUM_REGS; i++) rf[i] = $urandom;
   endtask

   // Expected dump: every register in ascending order with its current contents.
   task automatic check_beats(input string tag);
      checks++;
      if (obs_idx.size() != NUM_REGS) begin
         errors++;
         $display("FAIL %s beat_count: got %0d expected %0d", tag, obs_idx.size(), NUM_REGS);
      end
      for (int i = 0; i < obs_idx.size() && i < NUM_REGS; i++) begin
         checks++;
         if (obs_idx[i] !== i || obs_data[i] !== rf[i]) begin
            errors++;
            $display("FAIL %s beat[%0d]: got idx %0d data %0h expected idx %0d data %0h",
                     tag, i, obs_idx[i], obs_data[i], i, rf[i]);
         end
      end
   endtask

   task automatic check_run(input string tag, input int ncyc);
      checks++;
      if (obs_timeout) begin
         errors++;
         $display("FAIL %s timeout: got no done expected done within budget", tag);
      end
      checks++;
      if (obs_run != ncyc) begin
         errors++;
         $display("FAIL %s cpu_run_clocks: got %0d expected %0d", tag, obs_run, ncyc);
      end
      checks++;
      if (obs_final_cc != ncyc) begin
         errors++;
         $display("FAIL %s cycle_count: got %0d expected %0d", tag, obs_final_cc, ncyc);
      end
      checks++;
      if (obs_first_valid != ncyc + 1) begin
         errors++;
         $display("FAIL %s first_valid_clock: got %0d expected %0d", tag, obs_first_valid, ncyc + 1);
      end
      checks++;
      if (obs_hold_bad != 0 || obs_sel_bad != 0) begin
         errors++;
         $display("FAIL %s hold/select_errors: got %0d/%0d expected 0/0", tag, obs_hold_bad, obs_sel_bad);
      end
      for (int j = 0; j < obs_cc.size(); j++) begin
         checks++;
         if (obs_cc[j] != j) begin
            errors++;
            $display("FAIL %s run_count[%0d]: got %0d expected %0d", tag, j, obs_cc[j], j);
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (cpu_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s reset_flags: got run%0b busy%0b done%0b valid%0b expected all 0",
                  tag, cpu_run, busy, done, dump_valid);
      end
      checks++;
      if (cycle_count !== '0 || dump_idx !== '0 || dump_data !== '0) begin
         errors++;
         $display("FAIL %s reset_values: got cc %0d idx %0d data %0h expected 0 0 0",
                  tag, cycle_count, dump_idx, dump_data);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; num_cycles = '0; dump_ready = 1'b0; cpu_readRegA = 5'd9;
      repeat (3) step();
      check_all_zero("reset");
      checks++;
      if (rf_readRegA !== 5'd9) begin
         errors++;
         $display("FAIL reset rf_sel: got %0d expected 9", rf_readRegA);
      end
      #2 rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i * 3);
      run_dump(5, 0, -1, 1'b0);
      check_run("basic", 5);
      check_beats("basic");
      checks++;
      if (obs_min_gap != 2 || obs_max_gap != 2) begin
         errors++;
         $display("FAIL basic beat_spacing: got %0d..%0d expected 2..2", obs_min_gap, obs_max_gap);
      end
      repeat (3) step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || cpu_run !== 1'b0 || cycle_count !== 16'd5) begin
         errors++;
         $display("FAIL basic done_hold: got done%0b busy%0b run%0b cc %0d expected 1 0 0 5",
                  done, busy, cpu_run, cycle_count);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         int n;
         n = $urandom_range(1, 40);
         fill_rf_random();
         run_dump(n, 1, -1, 1'b0);
         check_run("random", n);
         check_beats("random");
      end
   endtask

   task automatic test_backpressure();
      int n;
      n = $urandom_range(1, 10);
      fill_rf_random();
      run_dump(n, 2, -1, 1'b0);
      check_run("backpressure", n);
      check_beats("backpressure");
      checks++;
      if (obs_stall != 4) begin
         errors++;
         $display("FAIL backpressure stall_clocks: got %0d expected 4", obs_stall);
      end
   endtask

   task automatic test_zero_cycles();
      fill_rf_random();
      run_dump(0, 0, -1, 1'b0);
      check_run("zero_cycles", 0);
      check_beats("zero_cycles");
   endtask

   task automatic test_reset_mid_scan();
      fill_rf_random();
      run_dump(4, 0, 12, 1'b0);
      #1;
      check_all_zero("abort");
      #2 rst_n = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort idle_after_reset: got busy%0b done%0b expected 0 0", busy, done);
      end
      fill_rf_random();
      run_dump(2, 0, -1, 1'b0);
      check_run("abort_restart", 2);
      check_beats("abort_restart");
   endtask

   task automatic test_start_ignored_and_restart();
      fill_rf_random();
      run_dump(6, 0, -1, 1'b1);
      check_run("start_ignored", 6);
      check_beats("start_ignored");
      fill_rf_random();
      run_dump(3, 1, -1, 1'b0);
      check_run("restart_from_done", 3);
      check_beats("restart_from_done");
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_zero_cycles();
      test_reset_mid_scan();
      test_start_ignored_and_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
